// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline stage register with a 2-entry skid buffer, flush-to-NOP and a
// saturating count of entries discarded by flush.
module pipe_stage_skid #(
  parameter int unsigned      WIDTH   = 16,
  parameter logic [WIDTH-1:0] NOP_VAL = '0,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic               out_valid_q, in_ready_q;
  logic               accept, drain;
  logic [1:0]         occ;
  logic [2:0]         dropped;
  logic [CNT_W:0]     cnt_sum;

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready;

  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    skid_d     = skid_q;
    drop_cnt_d = drop_cnt_q;
    occ        = 2'd0;
    dropped    = 3'd0;
    cnt_sum    = '0;

    unique case (state_q)
      StEmpty: begin
        occ = 2'd0;
        if (accept) begin
          state_d = StOne;
          main_d  = in_data;
        end
      end
      StOne: begin
        occ = 2'd1;
        if (accept && drain) begin
          main_d = in_data;
        end else if (accept) begin
          state_d = StTwo;
          skid_d  = in_data;
        end else if (drain) begin
          state_d = StEmpty;
          main_d  = NOP_VAL;
        end
      end
      StTwo: begin
        occ = 2'd2;
        if (drain) begin
          state_d = StOne;
          main_d  = skid_q;
          skid_d  = NOP_VAL;
        end
      end
      default: state_d = StEmpty;
    endcase

    // Drained entry reaches the consumer; everything else held or arriving is discarded.
    if (flush) begin
      state_d = StEmpty;
      main_d  = NOP_VAL;
      skid_d  = NOP_VAL;
      dropped = {1'b0, occ} - {2'b00, drain} + {2'b00, accept};
      cnt_sum = {1'b0, drop_cnt_q} + (CNT_W+1)'(dropped);
      drop_cnt_d = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StEmpty;
      main_q      <= NOP_VAL;
      skid_q      <= NOP_VAL;
      drop_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      drop_cnt_q  <= drop_cnt_d;
      out_valid_q <= (state_d != StEmpty);
      in_ready_q  <= (state_d != StTwo);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occ;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: the driver queues expected payloads on accept,
// a negedge monitor pops and compares them on every output handshake.
module tb_pipe_stage_skid;

  localparam int unsigned      WIDTH = 16;
  localparam int unsigned      CNT_W = 8;
  localparam logic [WIDTH-1:0] NOP   = 16'h0BAD;

  logic             CLK = 1'b0;
  logic             RST;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] drop_cnt;

  logic [WIDTH-1:0] exp_q[$];
  int               n_vec = 0;
  int               n_err = 0;
  logic             mon_en = 1'b0;

  pipe_stage_skid #(
    .WIDTH  (WIDTH),
    .NOP_VAL(NOP),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy),
    .drop_cnt (drop_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; a clean accept (no flush, no reset) queues its payload.
  task automatic cyc(input logic iv, input logic [WIDTH-1:0] d, input logic ordy,
                     input logic fl, output logic acc);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    acc       = iv && in_ready && !RST;
    if (acc && !fl) exp_q.push_back(d);
    @(posedge CLK);
    #1;
    if (fl || RST) exp_q.delete();
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", {16'h0, out_data}, 32'hFFFF_FFFF);
          end else begin
            check("out_data_order", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
          end
        end
      end else begin
        check("idle_out_data_nop", {16'h0, out_data}, {16'h0, NOP});
      end
    end
  end

  initial begin
    logic acc;
    int   tries;

    // 1: reset holds everything empty even with a valid input presented
    RST = 1'b1;
    flush = 1'b0;
    in_valid = 1'b1;
    in_data = 16'h1234;
    out_ready = 1'b0;
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_data",  {16'h0, out_data},  {16'h0, NOP});
    check("rst_in_ready",  {31'h0, in_ready},  32'h1);
    check("rst_occ",       {30'h0, occupancy}, 32'h0);
    check("rst_drop_cnt",  {24'h0, drop_cnt},  32'h0);
    RST = 1'b0;
    mon_en = 1'b1;

    // idle input with garbage payload must not be captured
    cyc(1'b0, 16'hDEAD, 1'b1, 1'b0, acc);
    check("idle_no_capture_occ", {30'h0, occupancy}, 32'h0);

    // 2: full-throughput stream
    cyc(1'b1, 16'h1111, 1'b1, 1'b0, acc);
    check("stream_latency_valid", {31'h0, out_valid}, 32'h1);
    check("stream_data0", {16'h0, out_data}, 32'h1111);
    check("stream_in_ready0", {31'h0, in_ready}, 32'h1);
    cyc(1'b1, 16'h2222, 1'b1, 1'b0, acc);
    check("stream_data1", {16'h0, out_data}, 32'h2222);
    check("stream_in_ready1", {31'h0, in_ready}, 32'h1);
    cyc(1'b1, 16'h3333, 1'b1, 1'b0, acc);
    check("stream_data2", {16'h0, out_data}, 32'h3333);
    check("stream_in_ready2", {31'h0, in_ready}, 32'h1);
    cyc(1'b0, 16'hDEAD, 1'b1, 1'b0, acc);
    check("stream_drained_occ", {30'h0, occupancy}, 32'h0);

    // 3: backpressure fills the skid, producer holds CCCC until space frees
    cyc(1'b1, 16'hAAAA, 1'b0, 1'b0, acc);
    cyc(1'b1, 16'hBBBB, 1'b0, 1'b0, acc);
    check("bp_occ2", {30'h0, occupancy}, 32'h2);
    check("bp_in_ready0", {31'h0, in_ready}, 32'h0);
    check("bp_head", {16'h0, out_data}, 32'hAAAA);
    cyc(1'b1, 16'hCCCC, 1'b0, 1'b0, acc);
    check("bp_hold_no_accept", {31'h0, acc}, 32'h0);
    check("bp_hold_occ2", {30'h0, occupancy}, 32'h2);
    tries = 0;
    do begin
      cyc(1'b1, 16'hCCCC, 1'b1, 1'b0, acc);
      tries++;
    end while (!acc && tries < 5);
    check("bp_cccc_accepted", {31'h0, acc}, 32'h1);
    check("bp_cccc_tries", tries, 2);
    repeat (3) cyc(1'b0, 16'hDEAD, 1'b1, 1'b0, acc);
    check("bp_queue_empty", exp_q.size(), 0);
    check("bp_final_occ", {30'h0, occupancy}, 32'h0);

    // 4: flush at occupancy 2 with consumer stalled drops both
    cyc(1'b1, 16'h5A5A, 1'b0, 1'b0, acc);
    cyc(1'b1, 16'h6B6B, 1'b0, 1'b0, acc);
    check("fl2_pre_occ", {30'h0, occupancy}, 32'h2);
    cyc(1'b0, 16'hDEAD, 1'b0, 1'b1, acc);
    check("fl2_occ", {30'h0, occupancy}, 32'h0);
    check("fl2_out_valid", {31'h0, out_valid}, 32'h0);
    check("fl2_out_data", {16'h0, out_data}, {16'h0, NOP});
    check("fl2_in_ready", {31'h0, in_ready}, 32'h1);
    check("fl2_drop_cnt", {24'h0, drop_cnt}, 32'd2);

    // 5: occ 1, flush with drain and accept together: old main delivered, new input dropped
    cyc(1'b1, 16'h4444, 1'b0, 1'b0, acc);
    cyc(1'b1, 16'h5555, 1'b1, 1'b1, acc);
    check("fl1_occ", {30'h0, occupancy}, 32'h0);
    check("fl1_drop_cnt", {24'h0, drop_cnt}, 32'd3);

    // flush with nothing held and no accept leaves the count alone
    cyc(1'b0, 16'hDEAD, 1'b1, 1'b1, acc);
    check("fl0_drop_cnt", {24'h0, drop_cnt}, 32'd3);

    // flush at occ 1 with no drain and no accept drops one
    cyc(1'b1, 16'h7A7A, 1'b0, 1'b0, acc);
    cyc(1'b0, 16'hDEAD, 1'b0, 1'b1, acc);
    check("fl_hold1_drop_cnt", {24'h0, drop_cnt}, 32'd4);

    // 6: saturation after many single-entry flushes
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, 16'(i), 1'b0, 1'b1, acc);
      if (i == 99) check("sat_mid_drop_cnt", {24'h0, drop_cnt}, 32'd104);
    end
    check("sat_drop_cnt", {24'h0, drop_cnt}, 32'd255);
    cyc(1'b1, 16'h0001, 1'b0, 1'b1, acc);
    check("sat_no_wrap", {24'h0, drop_cnt}, 32'd255);

    // reset dominates flush at occupancy 2
    cyc(1'b1, 16'h7777, 1'b0, 1'b0, acc);
    cyc(1'b1, 16'h8888, 1'b0, 1'b0, acc);
    check("rstfl_pre_occ", {30'h0, occupancy}, 32'h2);
    RST = 1'b1;
    cyc(1'b1, 16'h9999, 1'b0, 1'b1, acc);
    RST = 1'b0;
    check("rstfl_occ", {30'h0, occupancy}, 32'h0);
    check("rstfl_drop_cnt", {24'h0, drop_cnt}, 32'h0);
    check("rstfl_out_valid", {31'h0, out_valid}, 32'h0);
    check("rstfl_in_ready", {31'h0, in_ready}, 32'h1);

    // post-reset sanity transfer
    cyc(1'b1, 16'hABCD, 1'b1, 1'b0, acc);
    repeat (2) cyc(1'b0, 16'hDEAD, 1'b1, 1'b0, acc);
    check("end_queue_empty", exp_q.size(), 0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
